// File: rtl/sp_ram_ctrl.sv
// sp_ram_ctrl: initiator-side controller for a single-port RAM with a shared
// tri-state data bus, cs/we/oe strobes and a one-cycle registered read.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   req_valid/req_ready request handshake; accepted only in IDLE
//   req_we/req_addr/req_wdata  request type, address, write data
//   fill_start/fill_value      write fill_value to addresses 0..DEPTH-1
//   fill_done           one-cycle pulse in the first IDLE cycle after FILL
//   rsp_valid/rsp_rdata read response pulse; data held until next response
//   busy                high whenever the controller is not IDLE
//   mem_addr/mem_data/mem_cs/mem_we/mem_oe  RAM side, all registered
module sp_ram_ctrl #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic                  fill_start,
  input  logic [DATA_WIDTH-1:0] fill_value,
  output logic                  fill_done,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  inout  wire  [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ADDR,
    RD_DATA,
    FILL
  } state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    drive_en;

  // Bus is driven only from registers, so no path from req_* to the pads.
  assign mem_data = drive_en ? wdata_q : {DATA_WIDTH{1'bz}};

  // Single FSM: every output register is loaded with its value for the
  // state being entered, so strobes line up with the state itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      mem_cs    <= 1'b0;
      mem_we    <= 1'b0;
      mem_oe    <= 1'b0;
      mem_addr  <= '0;
      drive_en  <= 1'b0;
      wdata_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      fill_done <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      fill_done <= 1'b0;
      case (state)
        IDLE: begin
          if (fill_start) begin
            // FILL wins over a pending request; mem_addr doubles as counter.
            state     <= FILL;
            wdata_q   <= fill_value;
            mem_addr  <= '0;
            mem_cs    <= 1'b1;
            mem_we    <= 1'b1;
            drive_en  <= 1'b1;
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end else if (req_valid) begin
            mem_addr  <= req_addr;
            wdata_q   <= req_wdata;
            mem_cs    <= 1'b1;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (req_we) begin
              state    <= WR;
              mem_we   <= 1'b1;
              drive_en <= 1'b1;
            end else begin
              state    <= RD_ADDR;
            end
          end
        end

        WR: begin
          state     <= IDLE;
          mem_cs    <= 1'b0;
          mem_we    <= 1'b0;
          drive_en  <= 1'b0;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end

        // RAM latches its word at the end of this cycle; enable its driver next.
        RD_ADDR: begin
          state  <= RD_DATA;
          mem_oe <= 1'b1;
        end

        RD_DATA: begin
          rsp_rdata <= mem_data;
          rsp_valid <= 1'b1;
          state     <= IDLE;
          mem_cs    <= 1'b0;
          mem_oe    <= 1'b0;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end

        FILL: begin
          if (mem_addr == LAST_ADDR) begin
            fill_done <= 1'b1;
            state     <= IDLE;
            mem_cs    <= 1'b0;
            mem_we    <= 1'b0;
            drive_en  <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            mem_addr <= mem_addr + ADDR_WIDTH'(1);
          end
        end

        default: begin
          state     <= IDLE;
          mem_cs    <= 1'b0;
          mem_we    <= 1'b0;
          mem_oe    <= 1'b0;
          drive_en  <= 1'b0;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sp_ram_ctrl.sv
// tb_sp_ram_ctrl: directed and randomized bench for sp_ram_ctrl with a
// behavioural single-port RAM on the shared bus and a shadow-memory model.
module tb_sp_ram_ctrl;

  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          fill_start = 1'b0;
  logic [DW-1:0] fill_value = '0;
  logic          fill_done;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          busy;
  logic [AW-1:0] mem_addr;
  wire  [DW-1:0] mem_data;
  logic          mem_cs;
  logic          mem_we;
  logic          mem_oe;

  sp_ram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .fill_start (fill_start),
    .fill_value (fill_value),
    .fill_done  (fill_done),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .busy       (busy),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_cs     (mem_cs),
    .mem_we     (mem_we),
    .mem_oe     (mem_oe)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM: write on cs&we, registered read word,
  // drives the bus only while cs&oe&!we.
  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] ram_dout;
  always @(posedge clk) begin
    if (mem_cs) begin
      if (mem_we) ram[mem_addr] <= mem_data;
      else        ram_dout      <= ram[mem_addr];
    end
  end
  assign mem_data = (mem_cs && mem_oe && !mem_we) ? ram_dout : {DW{1'bz}};

  // Controller drives only with we, RAM only with oe: both at once is a clash.
  int bus_conflicts = 0;
  always @(negedge clk) begin
    if (mem_we && mem_oe) bus_conflicts++;
  end

  // Reference model state
  logic [DW-1:0] exp_mem [DEPTH];
  logic [DW-1:0] last_rd;
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 50) begin
      step();
      n++;
    end
    chk1("ready_timeout", req_ready, 1'b1);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wait_ready();
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    step();
    req_valid = 1'b0; req_addr = AW'($urandom); req_wdata = $urandom;
    chk1("wr_cs", mem_cs, 1'b1);
    chk1("wr_we", mem_we, 1'b1);
    chk1("wr_oe", mem_oe, 1'b0);
    chk("wr_addr", DW'(mem_addr), DW'(a));
    chk("wr_bus", mem_data, d);
    chk1("wr_ready", req_ready, 1'b0);
    chk1("wr_busy", busy, 1'b1);
    chk1("wr_rsp_valid", rsp_valid, 1'b0);
    chk("wr_rsp_hold", rsp_rdata, last_rd);
    exp_mem[a] = d;
    step();
    chk1("wr_done_ready", req_ready, 1'b1);
    chk1("wr_done_busy", busy, 1'b0);
    chk1("wr_done_cs", mem_cs, 1'b0);
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    wait_ready();
    req_valid = 1'b1; req_we = 1'b0; req_addr = a;
    step();
    req_valid = 1'b0; req_addr = AW'($urandom);
    chk1("rda_cs", mem_cs, 1'b1);
    chk1("rda_we", mem_we, 1'b0);
    chk1("rda_oe", mem_oe, 1'b0);
    chk("rda_addr", DW'(mem_addr), DW'(a));
    chk1("rda_ready", req_ready, 1'b0);
    step();
    chk1("rdd_cs", mem_cs, 1'b1);
    chk1("rdd_oe", mem_oe, 1'b1);
    chk1("rdd_we", mem_we, 1'b0);
    chk("rdd_addr", DW'(mem_addr), DW'(a));
    chk("rdd_bus", mem_data, exp_mem[a]);
    chk1("rdd_rsp_valid", rsp_valid, 1'b0);
    step();
    chk1("rsp_valid", rsp_valid, 1'b1);
    chk("rsp_rdata", rsp_rdata, exp_mem[a]);
    chk1("rsp_ready", req_ready, 1'b1);
    chk1("rsp_fill_done", fill_done, 1'b0);
    last_rd = exp_mem[a];
  endtask

  // Starts a FILL from IDLE and follows it to the fill_done cycle.
  task automatic do_fill(input logic [DW-1:0] v);
    wait_ready();
    fill_start = 1'b1; fill_value = v;
    step();
    fill_start = 1'b0; fill_value = $urandom;
    for (int i = 0; i < int'(DEPTH); i++) begin
      chk("fill_addr", DW'(mem_addr), DW'(i));
      chk1("fill_cs_we", mem_cs && mem_we, 1'b1);
      chk1("fill_oe", mem_oe, 1'b0);
      chk("fill_bus", mem_data, v);
      chk1("fill_ready", req_ready, 1'b0);
      chk1("fill_done_early", fill_done, 1'b0);
      exp_mem[i] = v;
      step();
    end
    chk1("fill_done", fill_done, 1'b1);
    chk1("fill_end_ready", req_ready, 1'b1);
    chk1("fill_end_busy", busy, 1'b0);
    chk1("fill_end_cs", mem_cs, 1'b0);
    chk1("fill_end_rsp", rsp_valid, 1'b0);
  endtask

  initial begin
    int pulses;
    last_rd = '0;

    // Reset values right after a 2-cycle reset
    step();
    step();
    rst = 1'b0;
    chk1("rst_ready", req_ready, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk("rst_rdata", rsp_rdata, '0);
    chk1("rst_cs", mem_cs, 1'b0);
    chk1("rst_we", mem_we, 1'b0);
    chk1("rst_oe", mem_oe, 1'b0);
    chk("rst_addr", DW'(mem_addr), '0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk1("rst_fill_done", fill_done, 1'b0);

    // FILL then spot-check both ends
    do_fill(32'h1234_5678);
    step();
    chk1("fill_done_single", fill_done, 1'b0);
    do_read(4'd0);
    do_read(4'd15);

    // Write/read
    do_write(4'd3, 32'hDEAD_BEEF);
    do_read(4'd3);

    // Back-to-back mixed traffic with no idle cycles
    do_write(4'd5, 32'h0000_0005);
    do_read(4'd5);
    do_write(4'd5, 32'h0000_000A);
    do_read(4'd5);

    // FILL beats a simultaneous request; request accepted at fill_done
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd9;
    do_fill(32'hA5A5_0000);
    do_read(4'd9);

    // Reset during RD_DATA
    step();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd2;
    step();
    req_valid = 1'b0;
    step();
    chk1("rrst_in_rdd", mem_oe, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk1("rrst_cs", mem_cs, 1'b0);
    chk1("rrst_we", mem_we, 1'b0);
    chk1("rrst_oe", mem_oe, 1'b0);
    chk1("rrst_rsp_valid", rsp_valid, 1'b0);
    chk("rrst_rdata", rsp_rdata, '0);
    chk1("rrst_ready", req_ready, 1'b1);
    last_rd = '0;
    step();
    chk1("rrst_rsp_after", rsp_valid, 1'b0);

    // Reset during FILL at address 7: no fill_done afterwards
    fill_start = 1'b1; fill_value = 32'hCAFE_F00D;
    step();
    fill_start = 1'b0;
    repeat (7) step();
    chk("frst_addr7", DW'(mem_addr), DW'(7));
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i <= 7; i++) exp_mem[i] = 32'hCAFE_F00D;
    chk1("frst_cs", mem_cs, 1'b0);
    chk1("frst_busy", busy, 1'b0);
    pulses = 0;
    repeat (20) begin
      if (fill_done) pulses++;
      step();
    end
    chk("frst_no_done", DW'(pulses), '0);
    do_read(4'd7);
    do_read(4'd8);

    // Randomized traffic against the shadow memory
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 1) == 1) do_write(AW'($urandom), $urandom);
      else                           do_read(AW'($urandom));
      if ($urandom_range(0, 3) == 0) step();
    end

    chk("bus_conflict", DW'(bus_conflicts), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
